// File: rtl/party_buttons_avs.sv
// Avalon-MM push-button peripheral: sync, debounce, press capture and maskable IRQ.
// Optional reaction timer compiled in when PARTY_BUTTONS_REACTION_TIMER_EN is defined.
module party_buttons_avs #(
    parameter int unsigned NUM_BUTTONS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons_n,
    input  logic [2:0]             avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic [31:0]            avs_readdata,
    output logic                   irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
    localparam logic [2:0] ADDR_RT_CTRL  = 3'd3;
    localparam logic [2:0] ADDR_RT_COUNT = 3'd4;

    logic [NUM_BUTTONS-1:0]            sync1_q, sync_q;
    logic [NUM_BUTTONS-1:0]            deb_q, deb_d;
    logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_BUTTONS-1:0]            edge_cap_q, edge_cap_d;
    logic [NUM_BUTTONS-1:0]            irq_mask_q, irq_mask_d;
    logic [31:0]                       readdata_q, readdata_d;
    logic [NUM_BUTTONS-1:0]            rise_c;
    logic [NUM_BUTTONS-1:0]            clr_c;
    logic [31:0]                       rdata_c;
    logic                              unused_wdata;

    // Write data above the button field is never consumed.
    assign unused_wdata = ^avs_writedata[31:NUM_BUTTONS];

    // Two-flop synchroniser on the inverted (active-high) pin value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= ~buttons_n;
            sync_q  <= sync1_q;
        end
    end

    // Per-button debounce: accept sync only after DEBOUNCE_CYCLES of disagreement.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TERM) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign rise_c = deb_d & ~deb_q;

    // Capture and mask registers; a new press beats a coincident W1C.
    always_comb begin
        irq_mask_d = irq_mask_q;
        clr_c      = '0;
        if (avs_write && (avs_address == ADDR_IRQ_MASK)) begin
            irq_mask_d = avs_writedata[NUM_BUTTONS-1:0];
        end
        if (avs_write && (avs_address == ADDR_EDGE_CAP)) begin
            clr_c = avs_writedata[NUM_BUTTONS-1:0];
        end
        edge_cap_d = (edge_cap_q & ~clr_c) | rise_c;
    end

`ifdef PARTY_BUTTONS_REACTION_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic [31:0] rt_count_q, rt_count_d;
    logic        armed_q, armed_d;
    logic        valid_q, valid_d;
    logic [3:0]  winner_q, winner_d;
    logic [3:0]  first_c;
    logic        rt_wr_c;

    assign rt_wr_c = avs_write && (avs_address == ADDR_RT_CTRL);

    // Lowest-index button rising this cycle.
    always_comb begin
        first_c = '0;
        for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
            if (rise_c[i]) begin
                first_c = 4'(i);
            end
        end
    end

    // Arming write has priority over a coincident press.
    always_comb begin
        timer_d    = timer_q;
        rt_count_d = rt_count_q;
        armed_d    = armed_q;
        valid_d    = valid_q;
        winner_d   = winner_q;
        if (armed_q && (timer_q != '1)) begin
            timer_d = timer_q + 32'd1;
        end
        if (rt_wr_c) begin
            timer_d = '0;
            armed_d = 1'b1;
            valid_d = 1'b0;
        end else if (armed_q && (|rise_c)) begin
            rt_count_d = timer_q;
            winner_d   = first_c;
            valid_d    = 1'b1;
            armed_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q    <= '0;
            rt_count_q <= '0;
            armed_q    <= 1'b0;
            valid_q    <= 1'b0;
            winner_q   <= '0;
        end else begin
            timer_q    <= timer_d;
            rt_count_q <= rt_count_d;
            armed_q    <= armed_d;
            valid_q    <= valid_d;
            winner_q   <= winner_d;
        end
    end
`endif

    // Read mux; unused bits and offsets read 0.
    always_comb begin
        rdata_c = '0;
        case (avs_address)
            ADDR_DATA:     rdata_c[NUM_BUTTONS-1:0] = deb_q;
            ADDR_IRQ_MASK: rdata_c[NUM_BUTTONS-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: rdata_c[NUM_BUTTONS-1:0] = edge_cap_q;
`ifdef PARTY_BUTTONS_REACTION_TIMER_EN
            ADDR_RT_CTRL:  rdata_c = {valid_q, armed_q, 26'd0, winner_q};
            ADDR_RT_COUNT: rdata_c = rt_count_q;
`endif
            default:       rdata_c = '0;
        endcase
        readdata_d = avs_read ? rdata_c : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q      <= '0;
            cnt_q      <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
        end else begin
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_party_buttons_avs.sv
// Scoreboard bench for party_buttons_avs with DEBOUNCE_CYCLES=8, NUM_BUTTONS=4.
module tb_party_buttons_avs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  buttons_n = 4'hF;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    logic rd_seen = 1'b0;

    party_buttons_avs #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .buttons_n     (buttons_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: readdata is valid on the cycle after a sampled read.
    always @(posedge clk) rd_seen <= avs_read;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_cur = exp_q.pop_front();
                chk(exp_cur.name, avs_readdata, exp_cur.val);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string name);
        exp_t x;
        x.name = name;
        x.val  = e;
        exp_q.push_back(x);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'd0, $sformatf("rst_reg%0d", a));
        end

        // Clean press on button 0
        wr(3'd1, 32'h1);
        buttons_n = 4'b1110;
        tick(9);
        chk("press_irq_pre", 32'(irq), 32'd0);
        rd(3'd0, 32'h0, "press_deb_pre");
        chk("press_irq", 32'(irq), 32'd1);
        rd(3'd0, 32'h1, "press_deb");
        rd(3'd2, 32'h1, "press_ecap");
        wr(3'd2, 32'h1);
        chk("w1c_irq", 32'(irq), 32'd0);
        rd(3'd2, 32'h0, "w1c_ecap");
        buttons_n = 4'b1111;
        tick(12);
        rd(3'd0, 32'h0, "release_deb");
        rd(3'd2, 32'h0, "release_no_cap");

        // Bounce on button 1
        buttons_n = 4'b1101;
        tick(5);
        buttons_n = 4'b1111;
        tick(1);
        buttons_n = 4'b1101;
        tick(9);
        rd(3'd0, 32'h0, "bounce_deb_pre");
        rd(3'd0, 32'h2, "bounce_deb");
        rd(3'd2, 32'h2, "bounce_ecap");
        chk("bounce_irq_masked", 32'(irq), 32'd0);
        buttons_n = 4'b1111;
        tick(9);
        rd(3'd0, 32'h2, "bounce_rel_pre");
        rd(3'd0, 32'h0, "bounce_rel");
        rd(3'd2, 32'h2, "bounce_rel_ecap");
        wr(3'd2, 32'h2);
        rd(3'd2, 32'h0, "bounce_clr");

        // Masked press on button 2, then unmask
        wr(3'd1, 32'h0);
        buttons_n = 4'b1011;
        tick(9);
        rd(3'd2, 32'h0, "ecap_same_edge");
        chk("masked_irq", 32'(irq), 32'd0);
        rd(3'd2, 32'h4, "masked_ecap");
        rd(3'd1, 32'h0, "mask_zero");
        wr(3'd1, 32'h4);
        chk("unmask_irq", 32'(irq), 32'd1);
        buttons_n = 4'b1111;
        tick(12);
        wr(3'd2, 32'h4);
        chk("mask_clr_irq", 32'(irq), 32'd0);

        // Set/clear collision on button 3
        buttons_n = 4'b0111;
        tick(9);
        wr(3'd2, 32'h8);
        rd(3'd2, 32'h8, "collide_set_wins");
        wr(3'd2, 32'h8);
        rd(3'd2, 32'h0, "collide_clr");
        buttons_n = 4'b1111;
        tick(12);

        // Unused offsets and upper bits
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'h0, "unused5");
        rd(3'd7, 32'h0, "unused7");
        wr(3'd1, 32'hFFFF_FFF4);
        rd(3'd1, 32'h4, "mask_upper");

`ifdef PARTY_BUTTONS_REACTION_TIMER_EN
        // Reaction timer: buttons 1 and 2 together, 100 cycles after arming
        wr(3'd3, 32'h0);
        rd(3'd3, 32'h4000_0000, "rt_armed");
        tick(99);
        buttons_n = 4'b1001;
        tick(12);
        rd(3'd3, 32'h8000_0001, "rt_ctrl");
        rd(3'd4, 32'd109, "rt_count");
        buttons_n = 4'b1111;
        tick(12);
        buttons_n = 4'b1110;
        tick(12);
        rd(3'd3, 32'h8000_0001, "rt_ctrl_hold");
        rd(3'd4, 32'd109, "rt_count_hold");
        buttons_n = 4'b1111;
        tick(12);
        // Re-arm coincides with a press: press ignored
        buttons_n = 4'b1110;
        tick(9);
        wr(3'd3, 32'h0);
        rd(3'd3, 32'h4000_0001, "rt_rearm_wins");
        rd(3'd4, 32'd109, "rt_rearm_count");
        buttons_n = 4'b1111;
        tick(12);
`else
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, 32'h0, "rt_ctrl_absent");
        rd(3'd4, 32'h0, "rt_count_absent");
`endif
        wr(3'd2, 32'hF);
        rd(3'd2, 32'h0, "pre_reset_clr");

        // Async reset mid-debounce with button 0 held and button 1 counting
        wr(3'd1, 32'h1);
        buttons_n = 4'b1110;
        tick(11);
        chk("prerst_irq", 32'(irq), 32'd1);
        rd(3'd0, 32'h1, "prerst_deb");
        buttons_n = 4'b1100;
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_readdata", avs_readdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(9);
        rd(3'd2, 32'h0, "postrst_ecap_pre");
        rd(3'd2, 32'h3, "postrst_ecap");
        rd(3'd0, 32'h3, "postrst_deb");
        rd(3'd1, 32'h0, "postrst_mask");
        chk("postrst_irq", 32'(irq), 32'd0);

        tick(3);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/party_buttons_avs.md
# party_buttons_avs

Avalon-MM responder peripheral that owns the four board push-buttons for the party-game Nios II system. It replaces the bare PIO behind `buttons_export`. It synchronises and debounces the active-low KEY pins and presents debounced state, per-button press capture and a maskable interrupt to the Nios II initiator. An optional reaction timer records which button was pressed first, and how many cycles after the game armed it.

## Interface
- `NUM_BUTTONS`, 4: number of button pins, 1..16.
- `DEBOUNCE_CYCLES`, 500000: stable-sample count required to accept a change (10 ms at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: reset, asynchronous, active-low; all state clears immediately on assertion.
- `buttons_n` in NUM_BUTTONS: raw KEY pins, active-low, asynchronous to `clk`.
- `avs_address` in 3: word address.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: read data, registered.
- `irq` out 1: level interrupt to Nios II.

## Operation
- Synchroniser: 2-flop per pin on the inverted pin value (`sync` = 1 means pressed).
- Debounce, per button:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  - If `sync` == `deb`, the counter clears to 0.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, `deb` takes `sync` and the counter clears.
  - A bounce back before terminal count restarts the count from 0.
- Edge capture: `edge_cap[i]` sets on the cycle `deb[i]` goes 0→1. Releases are not captured.
- `irq` = OR over (`edge_cap` & `irq_mask`), combinational from registers.
- Register map, word offsets; unused bits read 0:
  - 0 DATA (RO): `deb`.
  - 1 IRQ_MASK (RW): bits [NUM_BUTTONS-1:0].
  - 2 EDGE_CAP (W1C): write 1 to clear a bit. If a set and a clear of the same bit coincide, the set wins.
  - 3 RT_CTRL, 4 RT_COUNT: see Configuration.
  - 5–7: read 0, writes ignored.
- Read and write may not be asserted together; if they are, the write is performed and readdata is undefined.
- Reset values, all 0: `avs_readdata`, `irq`, `deb`, debounce counters, sync flops, `edge_cap`, `irq_mask`, all reaction-timer state.
- Because `deb` resets to 0, a button held through reset produces one press capture after DEBOUNCE_CYCLES. This is intended.

## Timing
- Read latency is 1 cycle: `avs_readdata` updates on the edge after `avs_read` is sampled and holds until the next read. There is no waitrequest.
- Writes take effect on the edge on which `avs_write` is sampled.
- Press latency: for a pin held stable low from cycle 0, `sync` rises at edge 2 and `deb` and `edge_cap` set at edge 2+DEBOUNCE_CYCLES. `irq` rises in that same cycle if the button is unmasked.
- After a W1C clear, `irq` deasserts in the cycle after the write edge, unless another masked capture bit is still set.
- A read of EDGE_CAP in the same cycle as a setting edge returns the pre-set value.

## Configuration
- `PARTY_BUTTONS_REACTION_TIMER_EN` defined: reaction timer is compiled in.
  - Any write to offset 3: clears the 32-bit timer, sets `armed`, clears `valid`.
  - While armed, the timer increments every cycle and saturates at 0xFFFFFFFF.
  - On the first cycle any `deb` bit rises while armed:
    - RT_COUNT latches the timer value, equal to the increments since arming.
    - `winner` takes the lowest index among the buttons rising that cycle.
    - `valid` sets and `armed` clears.
  - Presses while disarmed are ignored by the timer.
  - A write to offset 3 in the same cycle as a press re-arms; that press is not recorded.
  - RT_CTRL read layout: bit31 `valid`, bit30 `armed`, bits [3:0] `winner`.
- Macro undefined: no timer logic; offsets 3 and 4 behave as unused.

## Test plan
Bench uses DEBOUNCE_CYCLES=8 and NUM_BUTTONS=4.
- Clean press: drive `buttons_n`=4'b1110 and hold. `deb`=0001 and EDGE_CAP=0x1 exactly 10 cycles later; with IRQ_MASK=0x1, `irq`=1. Write 0x1 to offset 2: `irq`=0 the next cycle.
- Bounce: toggle pin 1 low for 5 cycles, high for 1, then hold low. `deb[1]` rises 10 cycles after the final low, and only one capture occurs. Release: `deb[1]` falls after 10 cycles and EDGE_CAP is unchanged.
- Masked press: IRQ_MASK=0, press button 2. EDGE_CAP=0x4 and `irq` stays 0. Write IRQ_MASK=0x4: `irq`=1 the next cycle.
- Set/clear collision: schedule a W1C of bit 3 on the same edge `deb[3]` rises. EDGE_CAP bit 3 reads 1 afterwards.
- Reaction timer, with the macro defined: write offset 3, then press buttons 1 and 2 simultaneously 100 cycles later. RT_CTRL reads 0x80000001 and RT_COUNT reads 109 (press + 2 sync + 8 debounce − 1). A later press changes nothing.
- Async reset mid-debounce: assert `reset_n`=0 with counters nonzero. All outputs read 0 before the next clock edge. After release with the pin still held, one capture occurs 10 cycles after reset deasserts.
